// File: rtl/ser2par.sv
// Bit-serial to W-bit word converter: collects W qualified bits, then presents
// the finished word on par_dout together with a one-cycle par_dout_valid strobe.
module ser2par #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ser_din,
  input  logic         ser_din_valid,
  output logic [W-1:0] par_dout,
  output logic         par_dout_valid
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  if (W < 2) begin : g_bad_w
    $error("ser2par: W must be >= 2");
  end

  logic [W-1:0]  shreg;
  logic [W-1:0]  shreg_nxt;
  logic [CW-1:0] cnt;
  logic          last_bit;

  // The completed word is taken from the next-state value so that it
  // already contains the bit accepted on the completing edge.
  if (MSB_FIRST) begin : g_msb
    assign shreg_nxt = {shreg[W-2:0], ser_din};
  end else begin : g_lsb
    assign shreg_nxt = {ser_din, shreg[W-1:1]};
  end

  assign last_bit = ser_din_valid && (cnt == LAST);

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      shreg          <= '0;
      cnt            <= '0;
      par_dout       <= '0;
      par_dout_valid <= 1'b0;
    end else begin
      par_dout_valid <= last_bit;
      if (ser_din_valid) begin
        shreg <= shreg_nxt;
        cnt   <= last_bit ? '0 : cnt + CW'(1);
      end
      if (last_bit) par_dout <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_ser2par.sv
// Directed bench for ser2par with W=8; one MSB-first and one LSB-first instance
// share the same clock, reset and serial stream.
module tb_ser2par;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       ser_din = 1'b0;
  logic       ser_din_valid = 1'b0;
  logic [7:0] dout_m, dout_l;
  logic       vld_m, vld_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nstrobe = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  logic [7:0] last_word = 8'h00;
  logic [7:0] prev_word = 8'h00;

  ser2par #(.W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .ser_din(ser_din), .ser_din_valid(ser_din_valid),
    .par_dout(dout_m), .par_dout_valid(vld_m)
  );

  ser2par #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .ser_din(ser_din), .ser_din_valid(ser_din_valid),
    .par_dout(dout_l), .par_dout_valid(vld_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log of the MSB-first instance
  always @(negedge clk) begin
    if (vld_m === 1'b1) begin
      nstrobe   = nstrobe + 1;
      prev_cyc  = last_cyc;
      last_cyc  = cyc;
      prev_word = last_word;
      last_word = dout_m;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_din = b;
    ser_din_valid = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ser_din = 1'bx;
      ser_din_valid = 1'b0;
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ser_din_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rstn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      idle(1);
      if (dout_m !== 8'h00 || vld_m !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_hold: %0d bad cycles, got dout=%h vld=%b, want 00/0", bad, dout_m, vld_m);
    end
    @(negedge clk);
    rstn = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (dout_m !== 8'h00 || vld_m !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_release_idle: %0d bad cycles, got dout=%h vld=%b, want 00/0", bad, dout_m, vld_m);
    end
  endtask

  task automatic test_gapped();
    int s0, gapbad;
    s0 = nstrobe;
    gapbad = 0;
    send_bit(0); send_bit(1); send_bit(1); send_bit(1);
    idle(1);
    if (vld_m !== 1'b0) gapbad++;
    send_bit(0); send_bit(0); send_bit(0);
    if (vld_m !== 1'b0) gapbad++;
    send_bit(1);
    checks++;
    if (gapbad != 0 || vld_m !== 1'b0) begin
      errors++;
      $display("FAIL gapped_no_early_strobe: early strobes=%0d vld=%b, want none", gapbad, vld_m);
    end
    idle(1);
    checks++;
    if (vld_m !== 1'b1 || dout_m !== 8'h71) begin
      errors++;
      $display("FAIL gapped_word: got vld=%b dout=%h, want 1/71", vld_m, dout_m);
    end
    idle(1);
    checks++;
    if (vld_m !== 1'b0 || dout_m !== 8'h71) begin
      errors++;
      $display("FAIL gapped_one_cycle: got vld=%b dout=%h, want 0/71", vld_m, dout_m);
    end
    checks++;
    if (nstrobe - s0 != 1) begin
      errors++;
      $display("FAIL gapped_strobe_count: got %0d, want 1", nstrobe - s0);
    end
  endtask

  task automatic test_partial();
    int s0;
    s0 = nstrobe;
    idle(1);
    send_bit(1);
    idle(15);
    checks++;
    if (nstrobe != s0 || dout_m !== 8'h71 || vld_m !== 1'b0) begin
      errors++;
      $display("FAIL partial_trailing: strobes=%0d dout=%h, want 0/71", nstrobe - s0, dout_m);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    pulse_reset();
    s0 = nstrobe;
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle(3);
    checks++;
    if (nstrobe - s0 != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes, want 2", nstrobe - s0);
    end
    checks++;
    if (prev_word !== 8'hA5 || last_word !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_words: got %h,%h, want a5,3c", prev_word, last_word);
    end
    checks++;
    if (last_cyc - prev_cyc != 8) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d clocks, want 8", last_cyc - prev_cyc);
    end
  endtask

  task automatic test_lsb_first();
    pulse_reset();
    send_byte(8'h80);
    idle(1);
    checks++;
    if (vld_l !== 1'b1 || dout_l !== 8'h01) begin
      errors++;
      $display("FAIL lsb_first_word: got vld=%b dout=%h, want 1/01", vld_l, dout_l);
    end
    checks++;
    if (vld_m !== 1'b1 || dout_m !== 8'h80) begin
      errors++;
      $display("FAIL lsb_first_msb_ref: got vld=%b dout=%h, want 1/80", vld_m, dout_m);
    end
    idle(1);
  endtask

  task automatic test_reset_midword();
    int s0;
    pulse_reset();
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    pulse_reset();
    s0 = nstrobe;
    send_bit(1); send_bit(1); send_bit(1);
    idle(1);
    checks++;
    if (vld_m !== 1'b0 || dout_m !== 8'h00) begin
      errors++;
      $display("FAIL midword_leftover: got vld=%b dout=%h, want 0/00", vld_m, dout_m);
    end
    send_bit(1); send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    idle(1);
    checks++;
    if (vld_m !== 1'b1 || dout_m !== 8'hFF) begin
      errors++;
      $display("FAIL midword_word: got vld=%b dout=%h, want 1/ff", vld_m, dout_m);
    end
    idle(10);
    checks++;
    if (nstrobe - s0 != 1) begin
      errors++;
      $display("FAIL midword_count: got %0d strobes, want 1", nstrobe - s0);
    end
  endtask

  task automatic test_reset_completion();
    pulse_reset();
    send_byte(8'h5A);
    idle(1);
    checks++;
    if (vld_m !== 1'b1 || dout_m !== 8'h5A) begin
      errors++;
      $display("FAIL completion_pre: got vld=%b dout=%h, want 1/5a", vld_m, dout_m);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (vld_m !== 1'b0 || dout_m !== 8'h00) begin
      errors++;
      $display("FAIL completion_async_reset: got vld=%b dout=%h, want 0/00", vld_m, dout_m);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_gapped();
    test_partial();
    test_back_to_back();
    test_lsb_first();
    test_reset_midword();
    test_reset_completion();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser2par.md
Name: ser2par

Overview:
- Serial-to-parallel converter: accumulates W qualified serial bits into one W-bit word.
- Emits the word with a one-cycle valid strobe.
- Sits between a bit-serial source (no backpressure) and a word-wide consumer.
- Gaps in the serial valid are tolerated; partial words persist across gaps.

Parameters:
- W, 8, parallel word width in bits; legal range W >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in par_dout[W-1]; 0 = first bit lands in par_dout[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-high (asserted = 1, despite the name).
- ser_din  input  1  serial data bit; sampled only when ser_din_valid = 1.
- ser_din_valid  input  1  qualifies ser_din for the current cycle.
- par_dout  output  W  last completed word; registered.
- par_dout_valid  output  1  one-cycle strobe marking a newly completed word; registered.

Behaviour:
- Reset (rstn = 1, async assert, sync-to-clk release in use):
  - shift register = 0; bit counter = 0; par_dout = 0; par_dout_valid = 0.
- Accept: on each rising clk with ser_din_valid = 1, shift ser_din into the internal shift register and increment the bit counter.
  - Counter width is clog2(W); it wraps W-1 -> 0.
- Shift direction:
  - MSB_FIRST = 1: shreg <= {shreg[W-2:0], ser_din}.
  - MSB_FIRST = 0: shreg <= {ser_din, shreg[W-1:1]}.
- Idle: ser_din_valid = 0 holds the shift register and counter unchanged. ser_din is don't-care (X allowed).
- Completion: when a valid bit is accepted with counter = W-1:
  - next cycle, par_dout = completed word (including that bit) and par_dout_valid = 1;
  - counter returns to 0.
- Latency: par_dout_valid rises one clock after the edge that sampled the W-th bit.
- par_dout_valid is high for exactly one cycle per word, then 0.
- par_dout holds its value until the next completion and never shows partial words.
- Back-to-back: a valid bit in the same cycle as par_dout_valid = 1 is accepted as bit 0 of the next word. No bubble; sustained throughput is 1 bit/clk.
- The 9th valid bit after reset starts word 2; there is no framing or resync input.
- Reset mid-word: asserting rstn discards the partial word and zeroes the counter. The next valid bit after release is bit 0.
- Reset in the completion cycle: par_dout_valid drops to 0 immediately (async) and par_dout clears to 0.
- No overflow/underflow conditions exist; no error outputs.

Decomposition:
- No shared package required.
- Counter width derived locally as $clog2(W).
- Single flat module; no sub-module is natural.
- Elaboration-time assertion that W >= 2.

Test Plan:
- Reset: hold rstn = 1 for 15 clocks with inputs idle -> par_dout = 0x00, par_dout_valid = 0 throughout. Release and idle 10 clocks -> outputs unchanged.
- Gapped word (W = 8, MSB_FIRST = 1):
  - bits 0,1,1,1, one idle cycle, bits 0,0,0,1;
  - -> par_dout_valid single pulse one clock after the 8th bit, par_dout = 0x71;
  - no strobe during the gap.
- Partial trailing word: after the 0x71 case, one idle cycle, then 1 valid bit (1), then 15 idle clocks -> no further strobe; par_dout stays 0x71.
- Back-to-back words (W = 8, MSB_FIRST = 1): 16 consecutive valid bits forming 0xA5 then 0x3C -> strobes exactly 8 clocks apart with par_dout = 0xA5 then 0x3C.
- LSB-first variant (MSB_FIRST = 0): send 1,0,0,0,0,0,0,0 -> par_dout = 0x01.
- Reset mid-word: 5 valid bits, pulse rstn, then 8 bits forming 0xFF -> exactly one strobe with par_dout = 0xFF. Leftover bits do not contaminate the word.
